regbank_responder: RTL and testbench

Register-bank responder on the datapath side of the control sequencer. Each cycle it consumes the sequencer's one-hot write-enable word (`regControl`) and the A/B read selects (`regACont`, `regBCont`), and writes the ALU result into the selected register. It drives the two operand buses back to the ALU, flags malformed write-enable words, and provides a sequential scan port that dumps all 16 registers for board-level display and verification.

---
 rtl/datapath_pkg.sv | 33 +++
 rtl/regbank_responder_onehot_check.sv | 34 +++
 rtl/regbank_responder.sv | 164 ++++++++++++++++
 tb/tb_regbank_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: bus widths, scan FSM states and the one-hot
// register write-enable words that the control sequencer also uses.
package datapath_pkg;

   localparam int WIDTH = 16;
   localparam int NREGS = 16;
   localparam int SEL_W = 4;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   localparam logic [NREGS-1:0] R0  = 16'h0001;
   localparam logic [NREGS-1:0] R1  = 16'h0002;
   localparam logic [NREGS-1:0] R2  = 16'h0004;
   localparam logic [NREGS-1:0] R3  = 16'h0008;
   localparam logic [NREGS-1:0] R4  = 16'h0010;
   localparam logic [NREGS-1:0] R5  = 16'h0020;
   localparam logic [NREGS-1:0] R6  = 16'h0040;
   localparam logic [NREGS-1:0] R7  = 16'h0080;
   localparam logic [NREGS-1:0] R8  = 16'h0100;
   localparam logic [NREGS-1:0] R9  = 16'h0200;
   localparam logic [NREGS-1:0] R10 = 16'h0400;
   localparam logic [NREGS-1:0] R11 = 16'h0800;
   localparam logic [NREGS-1:0] R12 = 16'h1000;
   localparam logic [NREGS-1:0] R13 = 16'h2000;
   localparam logic [NREGS-1:0] R14 = 16'h4000;
   localparam logic [NREGS-1:0] R15 = 16'h8000;

endpackage

// File: rtl/regbank_responder_onehot_check.sv
// Combinational classifier for the sequencer's write-enable word: tells the
// register bank whether exactly one bit is set, whether several are, and
// which register a single set bit points at.
module onehot_check
   import datapath_pkg::*;
(
   input  logic [NREGS-1:0] regControl,
   output logic             hit,
   output logic             multi,
   output logic [SEL_W-1:0] idx
);

   logic any_set;
   logic at_most_one;

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   always_comb begin
      any_set     = |regControl;
      at_most_one = ((regControl & (regControl - 16'd1)) == 16'd0);
      hit         = any_set & at_most_one;
      multi       = any_set & ~at_most_one;
   end

   // Priority encode the set bit; only meaningful when hit is high.
   always_comb begin
      idx = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (regControl[i]) begin
            idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/regbank_responder.sv
// Sixteen-entry register bank on the datapath side of the control sequencer.
// Writes the ALU result into the register named by a one-hot enable, serves
// two combinational operand reads, flags malformed enables and can stream
// the whole bank out through a scan port.
module regbank_responder
   import datapath_pkg::*;
#(
   parameter int WIDTH = datapath_pkg::WIDTH,
   parameter int NREGS = datapath_pkg::NREGS,
   parameter int CNT_W = datapath_pkg::CNT_W
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [15:0]      regControl,
   input  logic [3:0]       regACont,
   input  logic [3:0]       regBCont,
   input  logic [WIDTH-1:0] wrData,
   input  logic             errClr,
   input  logic             scanReq,
   output logic [WIDTH-1:0] busA,
   output logic [WIDTH-1:0] busB,
   output logic             errFlag,
   output logic [CNT_W-1:0] writeCount,
   output logic             scanValid,
   output logic [3:0]       scanIdx,
   output logic [WIDTH-1:0] scanData,
   output logic             scanDone,
   output logic             scanBusy
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [3:0]       LAST_REG = 4'(NREGS - 1);

   logic [WIDTH-1:0] regs [NREGS];

   logic       wr_hit;
   logic       wr_multi;
   logic [3:0] wr_idx;

   logic        scan_req_q;
   scan_state_t state;
   scan_state_t next_state;
   logic [3:0]  ptr;
   logic [3:0]  next_ptr;
   logic        next_valid;
   logic [3:0]  next_idx;
   logic [WIDTH-1:0] next_data;
   logic        next_done;

   onehot_check u_onehot_check (
      .regControl (regControl),
      .hit        (wr_hit),
      .multi      (wr_multi),
      .idx        (wr_idx)
   );

   // Register array: only a clean single-hot enable writes a register.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[wr_idx] <= wrData;
      end
   end

   // Operand buses read stored contents only, so a write shows up next cycle.
   always_comb begin
      busA = regs[regACont];
      busB = regs[regBCont];
   end

   // Sticky error flag; a malformed enable on the same edge beats a clear.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         errFlag <= 1'b0;
      end else if (wr_multi) begin
         errFlag <= 1'b1;
      end else if (errClr) begin
         errFlag <= 1'b0;
      end
   end

   // Count accepted writes, sticking at the top value instead of wrapping.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         writeCount <= '0;
      end else if (wr_hit && (writeCount != CNT_MAX)) begin
         writeCount <= writeCount + 1'b1;
      end
   end

   // The scan request is registered first, which puts the first beat two
   // cycles after the request is sampled.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         scan_req_q <= 1'b0;
      end else begin
         scan_req_q <= scanReq;
      end
   end

   // Scan FSM state, pointer and the registered scan port.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         ptr       <= '0;
         scanValid <= 1'b0;
         scanIdx   <= '0;
         scanData  <= '0;
         scanDone  <= 1'b0;
      end else begin
         state     <= next_state;
         ptr       <= next_ptr;
         scanValid <= next_valid;
         scanIdx   <= next_idx;
         scanData  <= next_data;
         scanDone  <= next_done;
      end
   end

   // Scan FSM next state and outputs; beats sample stored values, so a write
   // landing on the same edge is reported with its old contents.
   always_comb begin
      next_state = state;
      next_ptr   = ptr;
      next_valid = 1'b0;
      next_idx   = scanIdx;
      next_data  = scanData;
      next_done  = 1'b0;
      case (state)
         IDLE: begin
            if (scan_req_q) begin
               next_state = SCAN;
               next_ptr   = '0;
            end
         end
         SCAN: begin
            next_valid = 1'b1;
            next_idx   = ptr;
            next_data  = regs[ptr];
            next_ptr   = ptr + 4'd1;
            if (ptr == LAST_REG) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_done  = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            next_ptr   = '0;
         end
      endcase
   end

   // Busy covers the whole scan including the cycle the done pulse is shown.
   always_comb begin
      scanBusy = (state != IDLE) | scanDone;
   end

endmodule

// File: tb/tb_regbank_responder.sv
// Directed self-checking bench for regbank_responder.
module tb_regbank_responder;

   logic        clock;
   logic        Reset;
   logic [15:0] regControl;
   logic [3:0]  regACont;
   logic [3:0]  regBCont;
   logic [15:0] wrData;
   logic        errClr;
   logic        scanReq;
   logic [15:0] busA;
   logic [15:0] busB;
   logic        errFlag;
   logic [7:0]  writeCount;
   logic        scanValid;
   logic [3:0]  scanIdx;
   logic [15:0] scanData;
   logic        scanDone;
   logic        scanBusy;

   int testCount = 0;
   int failCount = 0;

   regbank_responder dut (
      .clock      (clock),
      .Reset      (Reset),
      .regControl (regControl),
      .regACont   (regACont),
      .regBCont   (regBCont),
      .wrData     (wrData),
      .errClr     (errClr),
      .scanReq    (scanReq),
      .busA       (busA),
      .busB       (busB),
      .errFlag    (errFlag),
      .writeCount (writeCount),
      .scanValid  (scanValid),
      .scanIdx    (scanIdx),
      .scanData   (scanData),
      .scanDone   (scanDone),
      .scanBusy   (scanBusy)
   );

   // Free-running clock, 10 time-unit period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one write-enable word and data across a single rising edge, then
   // settle 1 unit past the edge and drop the enable.
   task automatic applyStimulus(input logic [15:0] ctrl, input logic [15:0] data);
      regControl = ctrl;
      wrData     = data;
      @(posedge clock);
      #1;
      regControl = '0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busA"},       32'(busA), 32'h0);
      checkOutput({tag, "_busB"},       32'(busB), 32'h0);
      checkOutput({tag, "_errFlag"},    32'(errFlag), 32'h0);
      checkOutput({tag, "_writeCount"}, 32'(writeCount), 32'h0);
      checkOutput({tag, "_scanValid"},  32'(scanValid), 32'h0);
      checkOutput({tag, "_scanIdx"},    32'(scanIdx), 32'h0);
      checkOutput({tag, "_scanData"},   32'(scanData), 32'h0);
      checkOutput({tag, "_scanDone"},   32'(scanDone), 32'h0);
      checkOutput({tag, "_scanBusy"},   32'(scanBusy), 32'h0);
   endtask

   initial begin
      Reset      = 1'b0;
      regControl = '0;
      regACont   = 4'd0;
      regBCont   = 4'd1;
      wrData     = '0;
      errClr     = 1'b0;
      scanReq    = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkAllZero("reset");
      Reset = 1'b1;

      // Multi-hot enable: error, nothing written, count holds
      applyStimulus(16'h0003, 16'hFFFF);
      regACont = 4'd0;
      regBCont = 4'd1;
      #1;
      checkOutput("multi_errFlag", 32'(errFlag), 32'h1);
      checkOutput("multi_R0", 32'(busA), 32'h0);
      checkOutput("multi_R1", 32'(busB), 32'h0);
      checkOutput("multi_count", 32'(writeCount), 32'h0);
      errClr = 1'b1;
      applyStimulus(16'h0000, 16'h0000);
      errClr = 1'b0;
      checkOutput("errClr", 32'(errFlag), 32'h0);

      // Single write to R2, no bypass before the edge
      regACont   = 4'd2;
      regControl = 16'h0004;
      wrData     = 16'h0002;
      #1;
      checkOutput("noBypass", 32'(busA), 32'h0);
      applyStimulus(16'h0004, 16'h0002);
      checkOutput("writeR2_busA", 32'(busA), 32'h0002);
      checkOutput("writeR2_count", 32'(writeCount), 32'h1);

      // Write R3 and read both buses at once
      applyStimulus(16'h0008, 16'h0008);
      regACont = 4'd3;
      regBCont = 4'd2;
      #1;
      checkOutput("dual_busA", 32'(busA), 32'h0008);
      checkOutput("dual_busB", 32'(busB), 32'h0002);

      // Multi-hot and errClr on the same edge: error wins, R2/R3 untouched
      errClr = 1'b1;
      applyStimulus(16'h000C, 16'hFFFF);
      errClr = 1'b0;
      checkOutput("errWins_flag", 32'(errFlag), 32'h1);
      checkOutput("errWins_R3", 32'(busA), 32'h0008);
      checkOutput("errWins_R2", 32'(busB), 32'h0002);
      checkOutput("errWins_count", 32'(writeCount), 32'h2);
      errClr = 1'b1;
      applyStimulus(16'h0000, 16'h0000);
      errClr = 1'b0;
      checkOutput("errClr2", 32'(errFlag), 32'h0);

      // Load Ri = i+1
      for (int i = 0; i < 16; i++) begin
         applyStimulus(16'(16'h0001 << i), 16'(i + 1));
      end
      checkOutput("load_count", 32'(writeCount), 32'd18);

      // Full scan; R5 is rewritten on the edge that captures it
      scanReq = 1'b1;
      applyStimulus(16'h0000, 16'h0000);
      scanReq = 1'b0;
      checkOutput("scanIdleAfterReq_valid", 32'(scanValid), 32'h0);
      applyStimulus(16'h0000, 16'h0000);
      checkOutput("scanPrep_valid", 32'(scanValid), 32'h0);
      checkOutput("scanPrep_busy", 32'(scanBusy), 32'h1);
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            applyStimulus(16'h0020, 16'hAAAA);
         end else begin
            applyStimulus(16'h0000, 16'h0000);
         end
         checkOutput($sformatf("beat%0d_valid", i), 32'(scanValid), 32'h1);
         checkOutput($sformatf("beat%0d_idx", i), 32'(scanIdx), 32'(i));
         checkOutput($sformatf("beat%0d_data", i), 32'(scanData), 32'(i + 1));
         checkOutput($sformatf("beat%0d_done", i), 32'(scanDone), 32'h0);
      end
      applyStimulus(16'h0000, 16'h0000);
      checkOutput("scanEnd_valid", 32'(scanValid), 32'h0);
      checkOutput("scanEnd_done", 32'(scanDone), 32'h1);
      checkOutput("scanEnd_busy", 32'(scanBusy), 32'h1);
      applyStimulus(16'h0000, 16'h0000);
      checkOutput("postScan_done", 32'(scanDone), 32'h0);
      checkOutput("postScan_busy", 32'(scanBusy), 32'h0);
      regACont = 4'd5;
      #1;
      checkOutput("R5_new", 32'(busA), 32'hAAAA);
      checkOutput("scan_count", 32'(writeCount), 32'd19);

      // Saturating write counter
      for (int k = 0; k < 300; k++) begin
         applyStimulus(16'(16'h0001 << (k % 16)), 16'(k));
      end
      checkOutput("saturate", 32'(writeCount), 32'd255);

      // Reset in the middle of a scan
      scanReq = 1'b1;
      applyStimulus(16'h0000, 16'h0000);
      scanReq = 1'b0;
      repeat (5) applyStimulus(16'h0000, 16'h0000);
      checkOutput("midScan_valid", 32'(scanValid), 32'h1);
      Reset = 1'b0;
      #1;
      checkAllZero("abort");
      @(posedge clock);
      #1;
      Reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(16'h0000, 16'h0000);
         checkOutput($sformatf("abort_noDone%0d", c), 32'(scanDone), 32'h0);
      end
      checkOutput("abort_busy", 32'(scanBusy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
